// File: rtl/coin_scan_ctrl_if.sv
// Coin RAM port plus draw-engine request/grant bundle between the scan controller and its RAM/draw side.
// Latency: none (wires only); mem_q is expected one cycle after mem_addr.
// Backpressure: draw engine holds draw_req until draw_gnt is seen.
interface coin_scan_ctrl_if;
    logic [4:0]  mem_addr;
    logic        mem_wren;
    logic [15:0] mem_data;
    logic [15:0] mem_q;
    logic        draw_req;
    logic [4:0]  draw_addr;
    logic        draw_gnt;

    // controller side
    modport master (
        output mem_addr, mem_wren, mem_data, draw_gnt,
        input  mem_q, draw_req, draw_addr
    );

    // RAM / draw-engine side
    modport slave (
        input  mem_addr, mem_wren, mem_data, draw_gnt,
        output mem_q, draw_req, draw_addr
    );
endinterface

// File: rtl/coin_scan_ctrl.sv
// Scans the coin table on start, erases coins inside the player box, counts score and live coins.
// Latency: 2 cycles per missed entry, 3 per hit, +1 DONE cycle; done = 2*NUM_COINS+hits+1 after start.
// Backpressure: start ignored while busy; draw engine only granted in IDLE and must hold its request.
module coin_scan_ctrl #(
    parameter int NUM_COINS = 10,
    parameter int PW        = 4,
    parameter int PH        = 4,
    parameter int SCORE_W   = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [7:0]         player_x,
    input  logic [6:0]         player_y,
    coin_scan_ctrl_if.master   bus,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] score,
    output logic [4:0]         coins_left
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CHECK, S_ERASE, S_DONE} state_t;

    localparam logic [4:0] LAST_IDX  = 5'(NUM_COINS - 1);
    localparam logic [4:0] INIT_LIVE = 5'(NUM_COINS);
    localparam logic [8:0] PW9       = 9'(PW);
    localparam logic [7:0] PH8       = 8'(PH);

    state_t               r_state;
    state_t               w_next;
    logic [4:0]           r_idx;
    logic [7:0]           r_px;
    logic [6:0]           r_py;
    logic [14:0]          r_entry;
    logic [4:0]           r_live;
    logic [SCORE_W-1:0]   r_score;
    logic [4:0]           r_coins_left;

    logic [7:0]           w_cx;
    logic [6:0]           w_cy;
    logic                 w_x_ok;
    logic                 w_y_ok;
    logic                 w_hit;
    logic                 w_last;

    // Hit test on the word arriving from RAM; widened sums so the box never wraps at the screen edge.
    assign w_cx   = bus.mem_q[14:7];
    assign w_cy   = bus.mem_q[6:0];
    assign w_x_ok = ({1'b0, w_cx} >= {1'b0, r_px}) && ({1'b0, w_cx} <= ({1'b0, r_px} + PW9));
    assign w_y_ok = ({1'b0, w_cy} >= {1'b0, r_py}) && ({1'b0, w_cy} <= ({1'b0, r_py} + PH8));
    assign w_hit  = bus.mem_q[15] & w_x_ok & w_y_ok;
    assign w_last = (r_idx == LAST_IDX);

    assign score      = r_score;
    assign coins_left = r_coins_left;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next state, RAM port mux and arbitration; the write is gated by reset so a pending erase is dropped.
    always_comb begin
        w_next        = r_state;
        bus.mem_addr  = r_idx;
        bus.mem_wren  = 1'b0;
        bus.mem_data  = '0;
        bus.draw_gnt  = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy         = 1'b0;
                bus.mem_addr = bus.draw_addr;
                bus.draw_gnt = bus.draw_req;
                if (start) w_next = S_READ;
            end
            S_READ:  w_next = S_CHECK;
            S_CHECK: begin
                if (w_hit)       w_next = S_ERASE;
                else if (w_last) w_next = S_DONE;
                else             w_next = S_READ;
            end
            S_ERASE: begin
                bus.mem_wren = resetn;
                bus.mem_data = resetn ? {1'b0, r_entry} : 16'h0000;
                w_next       = w_last ? S_DONE : S_READ;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: player latch, entry index, live counter, saturating score, coins_left snapshot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_idx        <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_entry      <= '0;
            r_live       <= '0;
            r_score      <= '0;
            r_coins_left <= INIT_LIVE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_px   <= player_x;
                        r_py   <= player_y;
                        r_idx  <= '0;
                        r_live <= '0;
                    end
                end
                S_CHECK: begin
                    r_entry <= bus.mem_q[14:0];
                    if (!w_hit) begin
                        r_live <= r_live + {4'd0, bus.mem_q[15]};
                        if (!w_last) r_idx <= r_idx + 5'd1;
                    end
                end
                S_ERASE: begin
                    if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + 1'b1;
                    if (!w_last) r_idx <= r_idx + 5'd1;
                end
                S_DONE: r_coins_left <= r_live;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_scan_ctrl.sv
// Bench for coin_scan_ctrl: RAM model, write scoreboard, and a second instance with a 2-bit score.
// Latency: done timing checked against 2*N+hits+1 from the start-accept cycle.
// Backpressure: draw grant checked while a request is held across a scan.
module tb_coin_scan_ctrl;
    localparam int N = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, start;
    logic [7:0]  px;
    logic [6:0]  py;
    logic        busy, done, busy2, done2;
    logic [7:0]  score;
    logic [1:0]  score2;
    logic [4:0]  cl, cl2;
    logic        dreq;
    logic [4:0]  daddr;

    coin_scan_ctrl_if u_if();
    coin_scan_ctrl_if u_if2();

    coin_scan_ctrl #(.NUM_COINS(N), .PW(4), .PH(4), .SCORE_W(8)) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .player_x(px), .player_y(py),
        .bus(u_if.master), .busy(busy), .done(done), .score(score), .coins_left(cl)
    );

    coin_scan_ctrl #(.NUM_COINS(N), .PW(4), .PH(4), .SCORE_W(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .start(start), .player_x(px), .player_y(py),
        .bus(u_if2.master), .busy(busy2), .done(done2), .score(score2), .coins_left(cl2)
    );

    // RAM models with a registered read port and a bench load path
    logic [15:0] ram [32];
    logic [15:0] ram2 [32];
    logic [15:0] q1, q2;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [15:0] ld_dat;

    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr]  <= ld_dat;
            ram2[ld_addr] <= ld_dat;
        end else begin
            if (u_if.mem_wren)  ram[u_if.mem_addr]   <= u_if.mem_data;
            if (u_if2.mem_wren) ram2[u_if2.mem_addr] <= u_if2.mem_data;
        end
        q1 <= ram[u_if.mem_addr];
        q2 <= ram2[u_if2.mem_addr];
    end

    assign u_if.mem_q      = q1;
    assign u_if2.mem_q     = q2;
    assign u_if.draw_req   = dreq;
    assign u_if.draw_addr  = daddr;
    assign u_if2.draw_req  = 1'b0;
    assign u_if2.draw_addr = 5'd0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t q_wr[$];

    logic [15:0] ref_ram [32];
    int exp_score  = 0;
    int exp_score2 = 0;

    // write monitor: every DUT write must match the head of the expected-write queue
    always @(negedge clk) begin
        #1;
        if (resetn && u_if.mem_wren) begin
            check("wr_expected", (q_wr.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (q_wr.size() > 0) begin
                wr_t w;
                w = q_wr.pop_front();
                check("wr_addr", {27'd0, u_if.mem_addr}, {27'd0, w.a});
                check("wr_data", {16'd0, u_if.mem_data}, {16'd0, w.d});
            end
        end
        if (resetn && busy && !u_if.mem_wren)
            check("data_zero", {16'd0, u_if.mem_data}, 32'd0);
    end

    task automatic set_coin(input int i, input bit ex, input int x, input int y);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 5'(i);
        ld_dat  = {ex, 8'(x), 7'(y)};
        ref_ram[i] = {ex, 8'(x), 7'(y)};
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic scan(input int px_i, input int py_i, input bit draw_chk, input bit restart);
        int hits = 0;
        int live = 0;
        int acc;
        bit got_done = 0;
        for (int i = 0; i < N; i++) begin
            int cx, cy;
            logic [15:0] e;
            e  = ref_ram[i];
            cx = int'(e[14:7]);
            cy = int'(e[6:0]);
            if (e[15] && cx >= px_i && cx <= px_i + 4 && cy >= py_i && cy <= py_i + 4) begin
                wr_t w;
                w.a = 5'(i);
                w.d = {1'b0, e[14:0]};
                q_wr.push_back(w);
                ref_ram[i][15] = 1'b0;
                hits++;
            end else begin
                live += int'(e[15]);
            end
        end
        exp_score  = (exp_score + hits > 255) ? 255 : exp_score + hits;
        exp_score2 = (exp_score2 + hits > 3) ? 3 : exp_score2 + hits;

        @(negedge clk);
        start = 1'b1;
        px    = 8'(px_i);
        py    = 7'(py_i);
        acc   = cyc;
        if (draw_chk) begin
            check("gnt_accept", {31'd0, u_if.draw_gnt}, 32'd1);
            check("addr_accept", {27'd0, u_if.mem_addr}, {27'd0, daddr});
        end
        @(negedge clk);
        start = 1'b0;
        px    = ~px;
        py    = ~py;
        for (int k = 0; k < 200 && !got_done; k++) begin
            if (draw_chk) check("gnt_busy", {31'd0, u_if.draw_gnt}, 32'd0);
            if (done) begin
                got_done = 1;
                check("done_cyc", cyc, acc + 2 * N + hits + 1);
            end else begin
                start = (restart && k == 4) ? 1'b1 : 1'b0;
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("done_seen", {31'd0, got_done}, 32'd1);
        @(negedge clk);
        check("score", {24'd0, score}, exp_score);
        check("score_sat", {30'd0, score2}, exp_score2);
        check("coins_left", {27'd0, cl}, live);
        check("idle_after", {31'd0, busy}, 32'd0);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("wr_drained", q_wr.size(), 32'd0);
        if (draw_chk) check("gnt_after", {31'd0, u_if.draw_gnt}, 32'd1);
        @(negedge clk);
        check("no_requeue", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int acc;
        resetn = 1'b0; start = 1'b0; px = '0; py = '0;
        dreq = 1'b0; daddr = '0; ld_en = 1'b0; ld_addr = '0; ld_dat = '0;
        for (int i = 0; i < 32; i++) set_coin(i, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;

        // reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_score", {24'd0, score}, 32'd0);
        check("rst_cl", {27'd0, cl}, 32'd10);
        check("rst_wren", {31'd0, u_if.mem_wren}, 32'd0);
        dreq = 1'b1; daddr = 5'd9;
        #1;
        check("idle_gnt", {31'd0, u_if.draw_gnt}, 32'd1);
        check("idle_addr", {27'd0, u_if.mem_addr}, 32'd9);
        dreq = 1'b0;

        // empty table
        scan(0, 0, 0, 0);

        // single hit among ten live coins
        for (int i = 0; i < N; i++) set_coin(i, 1, 100 + i, 100);
        set_coin(3, 1, 20, 30);
        scan(18, 28, 0, 0);
        check("ram3", {16'd0, ram[3]}, 32'h0A1E);

        // box edges and no wrap at the right screen edge
        set_coin(0, 1, 24, 32);
        set_coin(1, 1, 25, 32);
        scan(20, 28, 0, 0);
        check("edge_miss_live", {31'd0, ram[1][15]}, 32'd1);
        set_coin(2, 1, 2, 0);
        scan(254, 0, 0, 0);

        // draw request held through a scan, with an ignored second start
        dreq = 1'b1; daddr = 5'd7;
        @(negedge clk);
        check("draw_idle", {31'd0, u_if.draw_gnt}, 32'd1);
        scan(0, 0, 1, 1);
        dreq = 1'b0;

        // more hits to push the narrow score into saturation
        set_coin(4, 1, 50, 50);
        set_coin(5, 1, 52, 52);
        set_coin(6, 1, 54, 54);
        scan(50, 50, 0, 0);
        set_coin(9, 1, 10, 10);
        scan(8, 8, 0, 0);

        // reset asserted in the erase cycle drops the write
        set_coin(0, 1, 60, 60);
        @(negedge clk);
        start = 1'b1; px = 8'd60; py = 7'd60; acc = cyc;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("erase_wren", {31'd0, u_if.mem_wren}, 32'd1);
        resetn = 1'b0;
        #1;
        check("rst_gate_wren", {31'd0, u_if.mem_wren}, 32'd0);
        @(negedge clk);
        check("rst_erase_busy", {31'd0, busy}, 32'd0);
        check("rst_erase_score", {24'd0, score}, 32'd0);
        check("rst_erase_cl", {27'd0, cl}, 32'd10);
        check("rst_erase_ram", {31'd0, ram[0][15]}, 32'd1);
        resetn = 1'b1;
        exp_score  = 0;
        exp_score2 = 0;
        scan(60, 60, 0, 0);
        check("post_rst_erase", {16'd0, ram[0]}, {16'd0, 1'b0, 8'd60, 7'd60});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
